imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time controller for the instruction memory. Consumes a byte stream
//  (valid/ready), packs little-endian 32-bit words and writes them into
//  sequential instruction-memory addresses from 0. Holds the core stalled
//  until the image is loaded, then releases it. Sits between the host/UART
//  byte source and the instruction-memory write port.
// PARAMETERS
//  DEPTH   256  instruction-memory depth in 32-bit words
//  ADDR_W  8    word-address width; DEPTH <= 2**ADDR_W
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  start       in   1       1-cycle pulse: begin load (honoured in IDLE/DONE/ERROR only)
//  word_count  in   ADDR_W+1 number of words to load, sampled on accepted start
//  byte_valid  in   1       byte_data valid
//  byte_data   in   8       stream byte
//  byte_ready  out  1       loader accepts byte this cycle
//  mem_we      out  1       instruction-memory write strobe (1 cycle per word)
//  mem_addr    out  ADDR_W  word address for write
//  mem_wdata   out  32      word to write
//  cpu_stall   out  1       1 = core held; 0 = core may fetch
//  busy        out  1       load in progress
//  done        out  1       image loaded, level until next start/reset
//  error       out  1       checksum mismatch (0 when checksum compiled out)
// BEHAVIOUR
//  - Reset: state=IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//    cpu_stall=1, busy=0, done=0, error=0; byte/word counters cleared.
//  - States: IDLE, RECV, WRITE, CHECK (macro only), DONE, ERROR.
//  - IDLE/DONE/ERROR --start--> RECV; latch n=min(word_count,DEPTH);
//    done,error cleared; word index=0. If n==0: -> DONE next cycle, no writes.
//  - RECV: byte_ready=1, busy=1. Byte accepted iff byte_valid&&byte_ready;
//    byte k (0..3) lands in bits [8k+7:8k]. byte_valid low = wait, no timeout.
//    4th accept -> WRITE next cycle.
//  - WRITE: byte_ready=0; mem_we=1 for exactly one cycle with mem_addr=index,
//    mem_wdata=packed word. Then index++; index==n -> DONE (or CHECK), else RECV.
//    Byte-in to write latency: mem_we asserted cycle after 4th byte accept.
//  - DONE: cpu_stall=0, done=1, busy=0. ERROR: cpu_stall=1, error=1, busy=0.
//  - cpu_stall=1 in every state except DONE.
//  - start while busy: ignored. start and byte_valid same cycle in IDLE:
//    start taken, byte not accepted (byte_ready=0 that cycle).
//  - Reset mid-load: returns to reset state immediately; words already written
//    stay in memory; partial word discarded.
//  - mem_addr wraps never: n clamped to DEPTH.
// CONFIGURATION
//  IMEM_CHECKSUM_EN defined: after last WRITE enter CHECK; accept 4 more bytes
//    (little-endian) as checksum; compare with XOR of all n written words
//    (XOR of zero words = 0). Match -> DONE, mismatch -> ERROR. Cycle after
//    4th checksum byte the decision state is entered.
//  Undefined: no CHECK state, no extra bytes consumed, error tied to 0.
// TESTING
//  T1 reset mid-RECV after 2 bytes -> all outputs at reset values next cycle,
//     no mem_we ever for that word.
//  T2 start,word_count=2; bytes 78 56 34 12 EF BE AD DE -> mem_we@addr0=
//     32'h12345678, addr1=32'hDEADBEEF; done=1,cpu_stall=0 (+checksum if EN).
//  T3 byte_valid toggled 1/0 each cycle during load -> same memory result,
//     byte_ready stays 1 in RECV, mem_we pulses exactly once per word.
//  T4 word_count=0 -> DONE one cycle after start, zero writes, byte_ready never 1.
//  T5 word_count=300 (DEPTH=256) -> exactly 256 writes, last mem_addr=255.
//  T6 (IMEM_CHECKSUM_EN) T2 image + checksum bytes 97 E8 99 CC -> DONE;
//     checksum 00 00 00 00 -> ERROR, cpu_stall=1; start again -> RECV, error=0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a little-endian byte stream into 32-bit words, writes them to imem from 0, then releases the core.
// Optional IMEM_CHECKSUM_EN: trailing 4-byte XOR checksum decides DONE vs ERROR.
module imem_boot_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_stall,
   output logic              busy,
   output logic              done,
   output logic              error
);
`ifdef IMEM_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
`endif
   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
   state_t          state_q, state_d;
   logic [ADDR_W:0] n_q, n_d, idx_q, idx_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [31:0]     word_q, word_d;
`ifdef IMEM_CHECKSUM_EN
   logic [31:0]     csum_q, csum_d;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
`ifdef IMEM_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
`ifdef IMEM_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
`ifdef IMEM_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE, DONE, ERROR: if (start) begin
            n_d     = (word_count > DEPTH_N) ? DEPTH_N : word_count;
            idx_d   = '0;
            bcnt_d  = '0;
            word_d  = '0;
`ifdef IMEM_CHECKSUM_EN
            csum_d  = '0;
`endif
            state_d = (n_d == '0) ? DONE : RECV;
         end
         RECV: if (byte_valid) begin
            word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
            bcnt_d  = bcnt_q + 2'd1;
            state_d = (bcnt_q == 2'd3) ? WRITE : RECV;
         end
         WRITE: begin
            idx_d   = idx_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
            csum_d  = csum_q ^ word_q;
            state_d = (idx_d == n_q) ? CHECK : RECV;
`else
            state_d = (idx_d == n_q) ? DONE : RECV;
`endif
         end
`ifdef IMEM_CHECKSUM_EN
         // checksum reuses the packing register; last byte compared straight off the bus
         CHECK: if (byte_valid) begin
            word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3)
               state_d = ({byte_data, word_q[23:0]} == csum_q) ? DONE : ERROR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
`ifdef IMEM_CHECKSUM_EN
   assign byte_ready = (state_q == RECV) || (state_q == CHECK);
   assign busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
   assign error      = (state_q == ERROR);
`else
   assign byte_ready = (state_q == RECV);
   assign busy       = (state_q == RECV) || (state_q == WRITE);
   assign error      = 1'b0;
`endif
   assign mem_we    = (state_q == WRITE);
   assign mem_addr  = mem_we ? idx_q[ADDR_W-1:0] : '0;
   assign mem_wdata = mem_we ? word_q : '0;
   assign cpu_stall = (state_q != DONE);
   assign done      = (state_q == DONE);
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader; expected writes queued as bytes are sent.
module tb_imem_boot_loader;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   word_count = '0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = '0;
   logic              byte_ready, mem_we, cpu_stall, busy, done, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   int errors = 0, checks = 0, wr_cnt = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [31:0] img[$];
   bit ready_seen = 0;
   imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_stall(cpu_stall), .busy(busy), .done(done), .error(error)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      logic [ADDR_W+31:0] e;
      if (byte_ready) ready_seen = 1;
      if (mem_we) begin
         wr_cnt++;
         last_addr = mem_addr;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                        mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
            end
         end
      end
   end
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      while (!byte_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!byte_ready) begin
         errors++; checks++;
         $display("FAIL byte_timeout byte_ready=%b required 1", byte_ready);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask
   task automatic do_start(input int wc);
      @(posedge clk); #1;
      start = 1'b1;
      word_count = wc[ADDR_W:0];
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask
   task automatic load(input bit gap, input bit bad_sum);
      logic [31:0] w, x;
      x = '0;
      for (int i = 0; i < img.size(); i++) begin
         w = img[i];
         x ^= w;
         exp_q.push_back({ADDR_W'(i), w});
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (k == 3) begin
               @(negedge clk);
               checks++;
               if (mem_we !== 1'b1) begin
                  errors++;
                  $display("FAIL write_latency mem_we=%b required 1", mem_we);
               end
            end else if (gap) begin
               @(negedge clk);
               checks++;
               if (byte_ready !== 1'b1) begin
                  errors++;
                  $display("FAIL ready_in_gap byte_ready=%b required 1", byte_ready);
               end
               @(posedge clk); #1;
            end
         end
      end
`ifdef IMEM_CHECKSUM_EN
      if (img.size() > 0) send_word(bad_sum ? 32'h0 : x);
`else
      if (bad_sum) x = '0;
`endif
   endtask
   task automatic wait_end();
      int t = 0;
      @(negedge clk);
      while (!(done || error) && t < 100) begin
         t++;
         @(negedge clk);
      end
      if (!(done || error)) begin
         errors++; checks++;
         $display("FAIL end_timeout done=%b error=%b required done or error", done, error);
      end
   endtask
   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_stall, busy, done, error} !==
          {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s rdy=%b we=%b addr=%0d wd=%h stall=%b busy=%b done=%b err=%b required 0 0 0 0 1 0 0 0",
                  tag, byte_ready, mem_we, mem_addr, mem_wdata, cpu_stall, busy, done, error);
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      reset = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("idle_after_reset");
   endtask
   task automatic test_basic();
      int w0 = wr_cnt;
      img = '{32'h12345678, 32'hDEADBEEF};
      @(posedge clk); #1;
      start = 1'b1; word_count = 2; byte_valid = 1'b1; byte_data = 8'hAA;
      @(posedge clk); #1;
      start = 1'b0; byte_valid = 1'b0;
      checks++;
      if ({busy, byte_ready, cpu_stall, done} !== 4'b1110) begin
         errors++;
         $display("FAIL basic_recv busy/rdy/stall/done=%b required 1110", {busy, byte_ready, cpu_stall, done});
      end
      load(0, 0);
      wait_end();
      checks++;
      if ({done, cpu_stall, error, busy} !== 4'b1000) begin
         errors++;
         $display("FAIL basic_done done/stall/err/busy=%b required 1000", {done, cpu_stall, error, busy});
      end
      checks++;
      if (wr_cnt - w0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_writes count=%0d pending=%0d required 2 0", wr_cnt - w0, exp_q.size());
      end
   endtask
   task automatic test_toggle();
      int w0 = wr_cnt;
      img = '{32'h12345678, 32'hDEADBEEF};
      do_start(2);
      load(1, 0);
      wait_end();
      checks++;
      if (wr_cnt - w0 != 2 || done !== 1'b1) begin
         errors++;
         $display("FAIL toggle_writes count=%0d done=%b required 2 1", wr_cnt - w0, done);
      end
   endtask
   task automatic test_zero();
      int w0 = wr_cnt;
      @(posedge clk); #1;
      ready_seen = 0;
      start = 1'b1; word_count = 0; byte_valid = 1'b1; byte_data = 8'h55;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({done, cpu_stall, busy} !== 3'b100) begin
         errors++;
         $display("FAIL zero_done done/stall/busy=%b required 100", {done, cpu_stall, busy});
      end
      repeat (5) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      checks++;
      if (wr_cnt != w0 || ready_seen) begin
         errors++;
         $display("FAIL zero_nowrite writes=%0d ready_seen=%b required 0 0", wr_cnt - w0, ready_seen);
      end
   endtask
   task automatic test_clamp();
      int w0 = wr_cnt;
      img.delete();
      for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
      do_start(300);
      load(0, 0);
      wait_end();
      checks++;
      if (wr_cnt - w0 != DEPTH || last_addr !== 8'd255 || done !== 1'b1) begin
         errors++;
         $display("FAIL clamp writes=%0d last_addr=%0d done=%b required 256 255 1", wr_cnt - w0, last_addr, done);
      end
   endtask
   task automatic test_mid_reset();
      int w0 = wr_cnt;
      do_start(1);
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("mid_reset");
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_nowrite writes=%0d busy=%b required 0 0", wr_cnt - w0, busy);
      end
   endtask
`ifdef IMEM_CHECKSUM_EN
   task automatic test_checksum();
      img = '{32'h12345678, 32'hDEADBEEF};
      do_start(2);
      load(0, 0);
      wait_end();
      checks++;
      if ({done, error, cpu_stall} !== 3'b100) begin
         errors++;
         $display("FAIL sum_good done/err/stall=%b required 100", {done, error, cpu_stall});
      end
      do_start(2);
      load(0, 1);
      wait_end();
      checks++;
      if ({done, error, cpu_stall} !== 3'b011) begin
         errors++;
         $display("FAIL sum_bad done/err/stall=%b required 011", {done, error, cpu_stall});
      end
      do_start(2);
      checks++;
      if ({busy, error, byte_ready} !== 3'b101) begin
         errors++;
         $display("FAIL sum_restart busy/err/rdy=%b required 101", {busy, error, byte_ready});
      end
      load(0, 0);
      wait_end();
   endtask
`endif
   initial begin
      #3000000;
      $display("FAIL watchdog expired required finish");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_zero();
      test_clamp();
      test_mid_reset();
      test_basic();
`ifdef IMEM_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
